// File: rtl/vector_select_stage.sv
`default_nettype none
// ============================================================================
// Module   : vector_select_stage
// Purpose  : Picks one of NUM_SRC signed source vectors, optionally broadcasts
//            a single lane of it, merges the result per lane with the old
//            destination under a write mask, and presents it through a
//            two-entry valid/ready skid buffer (main + skid register).
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            in_valid_i/in_ready_o   - input handshake
//            src_i, dst_i        - source vectors / old destination vector
//            sel_i, mode_i       - source index / 0 lane-wise, 1 broadcast
//            bcast_lane_i        - lane broadcast when mode_i = 1
//            mask_i              - per-lane write enable
//            out_valid_o/out_ready_i - output handshake
//            out_o, sel_err_o    - result vector / out-of-range select flag
// Revision : 1.0 - initial release
// ============================================================================
module vector_select_stage #(
    parameter  int DATA_WIDTH    = 16,
    parameter  int VECTOR_LENGTH = 16,
    parameter  int NUM_SRC       = 4,
    localparam int SEL_W         = $clog2(NUM_SRC),
    localparam int LANE_W        = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic signed [DATA_WIDTH-1:0] src_i [NUM_SRC][VECTOR_LENGTH],
    input  logic signed [DATA_WIDTH-1:0] dst_i [VECTOR_LENGTH],
    input  logic        [SEL_W-1:0]      sel_i,
    input  logic                         mode_i,
    input  logic        [LANE_W-1:0]     bcast_lane_i,
    input  logic        [VECTOR_LENGTH-1:0] mask_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic signed [DATA_WIDTH-1:0] out_o [VECTOR_LENGTH],
    output logic                         sel_err_o
);

    localparam logic [SEL_W:0] c_NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] w_src   [VECTOR_LENGTH];
    logic signed [DATA_WIDTH-1:0] w_bcast;
    logic signed [DATA_WIDTH-1:0] w_res   [VECTOR_LENGTH];
    logic                         w_sel_err;

    assign w_sel_err = !({1'b0, sel_i} < c_NUM_SRC_EXT);

    // An out-of-range index matches no entry and so falls back to src_i[0].
    always_comb begin
        w_src = src_i[0];
        for (int s = 1; s < NUM_SRC; s++) begin
            if (sel_i == SEL_W'(s)) begin
                w_src = src_i[s];
            end
        end
    end

    // Same fallback idea for the broadcast lane: unmatched index uses lane 0.
    always_comb begin
        w_bcast = w_src[0];
        for (int l = 1; l < VECTOR_LENGTH; l++) begin
            if (bcast_lane_i == LANE_W'(l)) begin
                w_bcast = w_src[l];
            end
        end
    end

    for (genvar i = 0; i < VECTOR_LENGTH; i++) begin : g_lane
        assign w_res[i] = !mask_i[i] ? dst_i[i] : (mode_i ? w_bcast : w_src[i]);
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   w_accept;
    logic   w_xfer;
    logic   w_load_main;
    logic   w_load_skid;
    logic   w_move_skid;

    // Ready is a pure decode of registered state: no combinational path
    // from out_ready_i back to in_ready_o.
    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_xfer      = out_valid_o && out_ready_i;

    always_comb begin
        state_d     = state_q;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_move_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    state_d     = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_xfer) begin
                    state_d     = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (!w_accept && w_xfer) begin
                    state_d     = ST_EMPTY;
                end else if (w_accept && w_xfer) begin
                    w_load_main = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_xfer) begin
                    state_d     = ST_ONE;
                    w_move_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Main / skid registers; sel_err travels alongside each beat
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] main_q [VECTOR_LENGTH];
    logic signed [DATA_WIDTH-1:0] skid_q [VECTOR_LENGTH];
    logic                         main_err_q;
    logic                         skid_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '{default: '0};
            skid_q     <= '{default: '0};
            main_err_q <= 1'b0;
            skid_err_q <= 1'b0;
        end else begin
            if (w_load_main) begin
                main_q     <= w_res;
                main_err_q <= w_sel_err;
            end else if (w_move_skid) begin
                main_q     <= skid_q;
                main_err_q <= skid_err_q;
            end
            if (w_load_skid) begin
                skid_q     <= w_res;
                skid_err_q <= w_sel_err;
            end
        end
    end

    assign out_o     = main_q;
    assign sel_err_o = main_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_select_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_select_stage
// Purpose  : Directed self-checking bench for vector_select_stage with
//            DATA_WIDTH=16, VECTOR_LENGTH=8, NUM_SRC=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_select_stage;

    localparam int DW = 16;
    localparam int VL = 8;
    localparam int NS = 3;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] src [NS][VL];
    logic signed [DW-1:0] dst [VL];
    logic        [1:0]    sel;
    logic                 mode;
    logic        [2:0]    bcast_lane;
    logic        [VL-1:0] mask;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_vec [VL];
    logic                 sel_err;

    int n_vec  = 0;
    int n_miss = 0;

    vector_select_stage #(
        .DATA_WIDTH    (DW),
        .VECTOR_LENGTH (VL),
        .NUM_SRC       (NS)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .src_i        (src),
        .dst_i        (dst),
        .sel_i        (sel),
        .mode_i       (mode),
        .bcast_lane_i (bcast_lane),
        .mask_i       (mask),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_o        (out_vec),
        .sel_err_o    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_out();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < VL; i++) r[i*DW +: DW] = out_vec[i];
        return r;
    endfunction

    // lanes base, base+1, ... base+7
    function automatic logic [127:0] pat(input int base);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < VL; i++) r[i*DW +: DW] = DW'(base + i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // beat whose result is purely the old destination (mask = 0)
    task automatic drive_dst_beat(input int base);
        for (int i = 0; i < VL; i++) dst[i] = DW'(base + i);
        mask     = '0;
        mode     = 1'b0;
        sel      = 2'd0;
        in_valid = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_valid"}, 128'(out_valid), 128'(1'b0));
        check_val({tag, "_ready"}, 128'(in_ready), 128'(1'b1));
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        sel        = 2'd2;
        mode       = 1'b0;
        bcast_lane = 3'd0;
        mask       = 8'hFF;
        for (int i = 0; i < VL; i++) begin
            src[0][i] = DW'(100 + i);
            src[1][i] = DW'(200 + i);
            src[2][i] = DW'(i - 4);
            dst[i]    = DW'(-1);
        end
        src[1][5] = 16'sh7FFF;

        // ---- reset values, in_valid held high during reset ----
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("rst");
            check_val("rst_out", pack_out(), 128'd0);
            check_val("rst_err", 128'(sel_err), 128'(1'b0));
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check_val("rst_nothing_accepted", 128'(out_valid), 128'(1'b0));

        // ---- lane-wise select ----
        sel = 2'd2; mode = 1'b0; mask = 8'hFF; in_valid = 1'b1;
        step();
        check_val("lane_valid", 128'(out_valid), 128'(1'b1));
        check_val("lane_out", pack_out(), pat(-4));
        check_val("lane_err", 128'(sel_err), 128'(1'b0));

        // ---- broadcast with mask merge ----
        sel = 2'd1; mode = 1'b1; bcast_lane = 3'd5; mask = 8'b1010_0101;
        for (int i = 0; i < VL; i++) dst[i] = DW'(-1);
        step();
        check_val("bcast_out", pack_out(),
                  128'h7FFF_FFFF_7FFF_FFFF_FFFF_7FFF_FFFF_7FFF);
        check_val("bcast_err", 128'(sel_err), 128'(1'b0));

        // ---- out-of-range select ----
        sel = 2'd3; mode = 1'b0; mask = 8'hFF;
        step();
        check_val("oor_out", pack_out(), pat(100));
        check_val("oor_err", 128'(sel_err), 128'(1'b1));

        // next beat in range, mask 0: result is dst and flag clears
        drive_dst_beat(50);
        step();
        check_val("after_oor_out", pack_out(), pat(50));
        check_val("after_oor_err", 128'(sel_err), 128'(1'b0));

        in_valid = 1'b0;
        step();
        check_idle("drain1");

        // ---- backpressure: A, B, C with out_ready = 0 ----
        out_ready = 1'b0;
        drive_dst_beat(16'h0A00);
        step();
        check_val("bp_A_out", pack_out(), pat(16'h0A00));
        check_val("bp_A_ready", 128'(in_ready), 128'(1'b1));
        drive_dst_beat(16'h0B00);
        step();
        check_val("bp_B_ready", 128'(in_ready), 128'(1'b0));
        check_val("bp_B_out_holdsA", pack_out(), pat(16'h0A00));
        drive_dst_beat(16'h0C00);
        for (int c = 0; c < 2; c++) begin
            step();
            check_val("bp_full_ready", 128'(in_ready), 128'(1'b0));
            check_val("bp_full_valid", 128'(out_valid), 128'(1'b1));
            check_val("bp_stable_out", pack_out(), pat(16'h0A00));
        end
        out_ready = 1'b1;
        step();
        check_val("bp_drain_B", pack_out(), pat(16'h0B00));
        check_val("bp_drain_B_valid", 128'(out_valid), 128'(1'b1));
        check_val("bp_drain_ready", 128'(in_ready), 128'(1'b1));
        step();
        check_val("bp_drain_C", pack_out(), pat(16'h0C00));
        check_val("bp_drain_C_valid", 128'(out_valid), 128'(1'b1));
        in_valid = 1'b0;
        step();
        check_idle("drain2");

        // ---- streaming, 10 beats, out_ready = 1 ----
        for (int k = 1; k <= 10; k++) begin
            drive_dst_beat(k * 16);
            step();
            check_val("stream_valid", 128'(out_valid), 128'(1'b1));
            check_val("stream_out", pack_out(), pat(k * 16));
            check_val("stream_ready", 128'(in_ready), 128'(1'b1));
        end
        in_valid = 1'b0;
        step();
        check_idle("drain3");

        // ---- mid-stream reset with two beats buffered ----
        out_ready = 1'b0;
        drive_dst_beat(16'h1100);
        step();
        drive_dst_beat(16'h2200);
        step();
        check_val("mr_full", 128'(in_ready), 128'(1'b0));
        #1;
        rst = 1'b1;
        #1;
        check_idle("mr_async");
        check_val("mr_out", pack_out(), 128'd0);
        drive_dst_beat(16'h3300);
        step();
        check_idle("mr_hold");
        rst       = 1'b0;
        out_ready = 1'b1;
        drive_dst_beat(16'h0D00);
        step();
        check_val("mr_D_valid", 128'(out_valid), 128'(1'b1));
        check_val("mr_D_out", pack_out(), pat(16'h0D00));
        in_valid = 1'b0;
        step();
        check_idle("mr_D_alone");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
